conv_out_stream: RTL
====================

// Module: conv_out_stream
// PURPOSE
//  Output stage directly downstream of the conv engine's data_out/data_out_valid (8 ch x int8 = 64 b).
//  The conv pipeline has no backpressure, so this block buffers its beats in a FIFO.
//  Re-emits the beats as an AXI4-Stream master toward the output DMA, with TLAST on the final beat
//  of a CPU-programmed beat count. Reports done, sticky overflow and excess errors, and FIFO fill.
// PARAMETERS
//  DATA_W   64    beat width; must equal the conv output packing (8 x 8 b)
//  DEPTH    1024  FIFO entries; power of 2, >= 4
//  CNT_W    32    beat counter width
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  cfg_out_beats  in   CNT_W   beats expected this job; latched on start
//  start          in   1       1-cycle pulse; begins a job when idle
//  busy           out  1       high from the cycle after an accepted start until done
//  done           out  1       1-cycle pulse after the TLAST handshake
//  overflow       out  1       sticky: an input beat was dropped because the FIFO was full
//  excess         out  1       sticky: an input beat arrived after cfg_out_beats inputs
//  fill_level     out  $clog2(DEPTH+1)  current FIFO occupancy
//  data_in        in   DATA_W  conv output beat (lane i = channel i, bits [8i+7:8i])
//  data_in_valid  in   1       qualifies data_in; no ready is returned
//  m_axis_tdata   out  DATA_W  stream data
//  m_axis_tvalid  out  1       stream valid
//  m_axis_tready  in   1       stream ready from the DMA
//  m_axis_tlast   out  1       marks beat index cfg_out_beats-1
// BEHAVIOUR
//  Reset: FSM=IDLE; FIFO emptied; in_cnt=out_cnt=0; every output 0 (busy, done, overflow, excess,
//    fill_level, tvalid, tlast, tdata).
//  FSM IDLE -> RUN -> FLUSH_DONE -> IDLE.
//   IDLE: start=1 latches cfg_out_beats, clears both counters and both sticky flags, and goes to RUN.
//     If cfg_out_beats==0, go to FLUSH_DONE instead. data_in_valid in IDLE is dropped silently.
//   RUN: busy=1.
//     Input side: a beat with data_in_valid=1 and in_cnt<beats is written and in_cnt increments.
//     If in_cnt==beats, the beat is dropped and excess<=1.
//     Output side: out_cnt increments on each tvalid&tready.
//     The handshake where out_cnt==beats-1 carries tlast=1 and moves the FSM to FLUSH_DONE.
//   FLUSH_DONE: done=1 for exactly 1 cycle, busy=0 in that cycle, then IDLE.
//  start while busy or in FLUSH_DONE: ignored; the latched config is unchanged.
//  FIFO: first-word-fall-through, registered write.
//   Beat written at edge N is visible on tdata with tvalid=1 from cycle N+1 (1-cycle latency when empty).
//   tdata/tvalid/tlast hold steady while tvalid&!tready (AXIS rule).
//   Full and a write with no read: beat dropped, overflow<=1, in_cnt still increments.
//     The dropped beat is still counted as input.
//   Full and a write with a simultaneous read: both proceed, no overflow.
//   Empty and a write: no same-cycle bypass; the read happens the cycle after.
//   fill_level updates the cycle after each write or read; it is unchanged on a simultaneous write+read.
//  tlast is a function of out_cnt only and is qualified by tvalid.
//  Overflow shortfall: if overflow dropped beats, fewer than beats reach the output and the FSM
//    stays in RUN. Software must recover with rst.
//  Sticky flags clear only on rst or an accepted start.
//  rst mid-job: FIFO contents are discarded; no done pulse is produced.
// STRUCTURE
//  conv_pkg: localparam CONV_OUT_W=64; typedef enum logic [1:0] {OS_IDLE, OS_RUN, OS_FLUSH_DONE} os_state_t.
//  Sub-module sync_fifo_fwft #(DATA_W, DEPTH): BRAM-inferable storage, count output, full/empty flags.
//  Top level contains only the FSM, the counters and the flags.
// TESTING
//  T1: beats=16; 16 inputs back-to-back; tready=1 -> 16 outputs in order, tlast on #15 only,
//      first tvalid 1 cycle after first input, done 1 cycle after the tlast handshake.
//  T2: beats=8; tready toggles 1010.. -> data held stable while stalled, same 8 beats, no overflow.
//  T3: DEPTH=4, beats=8, tready=0 for 8 inputs -> fill_level=4, overflow=1, only beats 0..3 are output
//      after release, FSM remains busy.
//  T4: beats=4; 6 inputs -> excess=1, 4 outputs, tlast on #3, done pulses.
//  T5: beats=0 start -> done the cycle after start, tvalid never asserted.
//  T6: rst asserted mid-RUN with 3 beats queued -> next cycle tvalid=0, fill_level=0, busy=0;
//      a new job with beats=2 then completes normally.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the conv output stage.
//   CONV_OUT_W  width of one conv output beat (8 channels x int8)
//   os_state_t  job sequencer states of conv_out_stream
package conv_pkg;

  localparam int CONV_OUT_W = 64;

  typedef enum logic [1:0] {
    OS_IDLE       = 2'd0,
    OS_RUN        = 2'd1,
    OS_FLUSH_DONE = 2'd2
  } os_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with a registered head word.
// The head of the queue lives in a register (rd_data / !empty); the remaining
// entries live in a RAM array read synchronously into the head register.
// A write into an empty FIFO lands in the head register at the clock edge, so
// it is visible the following cycle (no same-cycle bypass).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_en/wr_data write request; ignored when full unless a read happens in the same cycle
//   rd_ready      consumer accepts the head word this cycle (pop when !empty)
//   rd_data       head word, valid when !empty
//   full, empty   occupancy flags
//   count         occupancy, 0..DEPTH
module sync_fifo_fwft
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_OUT_W,
  parameter int DEPTH  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [DATA_W-1:0] head_data_r;
  logic              head_valid_r;

  logic full_s;
  logic mem_empty_s;
  logic pop_s;
  logic push_s;
  logic to_head_s;
  logic mem_wr_s;
  logic mem_rd_s;

  // Steering: the head register holds entry 0, so the RAM is non-empty only when count >= 2.
  always_comb begin
    full_s      = (count_r == CW'(DEPTH));
    mem_empty_s = (count_r < CW'(2'd2));
    pop_s       = head_valid_r & rd_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push_s      = wr_en & (~full_s | pop_s);
    to_head_s   = push_s & (~head_valid_r | (pop_s & mem_empty_s));
    mem_wr_s    = push_s & ~to_head_s;
    mem_rd_s    = pop_s & ~mem_empty_s;
  end

  // RAM write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and the head register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      head_data_r  <= {DATA_W{1'b0}};
      head_valid_r <= 1'b0;
    end else begin
      if (mem_wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (to_head_s) begin
        head_data_r  <= wr_data;
        head_valid_r <= 1'b1;
      end else if (mem_rd_s) begin
        head_data_r  <= mem_r[rd_ptr_r];
        head_valid_r <= 1'b1;
        rd_ptr_r     <= rd_ptr_r + AW'(1'b1);
      end else if (pop_s) begin
        head_valid_r <= 1'b0;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = head_data_r;
  assign empty   = ~head_valid_r;
  assign full    = full_s;
  assign count   = count_r;

endmodule

// File: rtl/conv_out_stream.sv
// conv_out_stream: buffers conv engine output beats (no backpressure upstream)
// and re-emits them as an AXI4-Stream master, asserting TLAST on beat
// cfg_out_beats-1 of a job.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cfg_out_beats, start           job length, latched by a start pulse while idle
//   busy, done                     job in progress / 1-cycle completion pulse
//   overflow, excess               sticky drop flags (FIFO full / more inputs than the job length)
//   fill_level                     FIFO occupancy
//   data_in, data_in_valid         conv output beats
//   m_axis_t{data,valid,ready,last} stream toward the output DMA
module conv_out_stream
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_OUT_W,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CNT_W-1:0]           cfg_out_beats,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic                       excess,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       data_in_valid,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast
);

  os_state_t        state_r;
  logic [CNT_W-1:0] beats_r;
  logic [CNT_W-1:0] in_cnt_r;
  logic [CNT_W-1:0] out_cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             overflow_r;
  logic             excess_r;

  logic fifo_wr_s;
  logic fifo_full_s;
  logic fifo_empty_s;
  logic in_room_s;
  logic hs_s;
  logic last_s;

  // Input admission, output handshake and last-beat decode.
  always_comb begin
    in_room_s = (in_cnt_r < beats_r);
    fifo_wr_s = (state_r == OS_RUN) & data_in_valid & in_room_s;
    hs_s      = ~fifo_empty_s & m_axis_tready;
    last_s    = (out_cnt_r == (beats_r - CNT_W'(1'b1)));
  end

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr_s),
    .wr_data  (data_in),
    .rd_ready (m_axis_tready),
    .rd_data  (m_axis_tdata),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fill_level)
  );

  // Job sequencer with beat counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= OS_IDLE;
      beats_r    <= {CNT_W{1'b0}};
      in_cnt_r   <= {CNT_W{1'b0}};
      out_cnt_r  <= {CNT_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      excess_r   <= 1'b0;
    end else begin
      case (state_r)
        OS_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            beats_r    <= cfg_out_beats;
            in_cnt_r   <= {CNT_W{1'b0}};
            out_cnt_r  <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
            excess_r   <= 1'b0;
            if (cfg_out_beats == {CNT_W{1'b0}}) begin
              state_r <= OS_FLUSH_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= OS_RUN;
              busy_r  <= 1'b1;
            end
          end
        end
        OS_RUN: begin
          if (data_in_valid) begin
            if (in_room_s) begin
              // A beat lost to a full FIFO still counts toward the job length.
              in_cnt_r <= in_cnt_r + CNT_W'(1'b1);
              if (fifo_full_s & ~hs_s) begin
                overflow_r <= 1'b1;
              end
            end else begin
              excess_r <= 1'b1;
            end
          end
          if (hs_s) begin
            out_cnt_r <= out_cnt_r + CNT_W'(1'b1);
            if (last_s) begin
              state_r <= OS_FLUSH_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end
          end
        end
        OS_FLUSH_DONE: begin
          done_r  <= 1'b0;
          state_r <= OS_IDLE;
        end
        default: begin
          state_r <= OS_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign overflow      = overflow_r;
  assign excess        = excess_r;
  assign m_axis_tvalid = ~fifo_empty_s;
  assign m_axis_tlast  = ~fifo_empty_s & last_s;

endmodule
